// File: rtl/data_mem_arb_pkg.sv
// rtl/data_mem_arb_pkg.sv - funct3 constants, arbiter state type and access-checking helpers
package data_mem_arb_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    function automatic logic f3_valid(input logic [2:0] f3, input logic we);
        logic ok;
        if (we) begin
            ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        end else begin
            ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
                 (f3 == F3_LBU) || (f3 == F3_LHU);
        end
        return ok;
    endfunction

    // Size lives in funct3[1:0]: 01 halfword, 10 word.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_mem_port_arbiter_streak.sv
// rtl/data_mem_port_arbiter_streak.sv - saturating D-grant streak counter with clear and limit compare
module arb_streak_ctr #(
    parameter int MAX = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_sat
);

    logic [3:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= 4'd0;
        end else if (i_clr) begin
            r_count <= 4'd0;
        end else if (i_inc && (r_count != 4'(MAX))) begin
            r_count <= r_count + 4'd1;
        end
    end

    assign o_sat = (r_count == 4'(MAX));

endmodule

// File: rtl/data_mem_port_arbiter.sv
// rtl/data_mem_port_arbiter.sv - shares one data-memory port between fetch and load/store
// Optional DATA_MEM_ARB_MISALIGN_EN adds o_d_misalign and suppresses misaligned D accesses.
module data_mem_port_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 8,
    parameter int MAX_D_STREAK = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [31:0]       o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [2:0]        i_d_funct3,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [31:0]       i_d_wdata,
    output logic              o_d_gnt,
    output logic              o_d_rvalid,
    output logic [31:0]       o_d_rdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [2:0]        o_mem_funct3,
    output logic [31:0]       o_mem_wdata,
    input  logic [31:0]       i_mem_rdata
`ifdef DATA_MEM_ARB_MISALIGN_EN
    ,
    output logic              o_d_misalign
`endif
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        w_sat;
    logic        w_d_win;
    logic        w_if_win;
    logic        w_d_valid;
    logic        w_d_access;
    logic [31:0] r_if_rdata;
    logic [31:0] r_d_rdata;

    // D keeps priority until it has won MAX_D_STREAK times in a row against a waiting fetch.
    assign w_d_win  = !i_rst && i_d_req && !(i_if_req && w_sat);
    assign w_if_win = !i_rst && i_if_req && !w_d_win;

    assign w_d_valid = f3_valid(i_d_funct3, i_d_we);

`ifdef DATA_MEM_ARB_MISALIGN_EN
    logic w_d_misal;
    logic r_d_misalign;

    assign w_d_misal  = w_d_valid && f3_misaligned(i_d_funct3, i_d_addr[1:0]);
    assign w_d_access = w_d_valid && !w_d_misal;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_d_misalign <= 1'b0;
        end else begin
            r_d_misalign <= w_d_win && w_d_misal;
        end
    end

    assign o_d_misalign = r_d_misalign;
`else
    assign w_d_access = w_d_valid;
`endif

    arb_streak_ctr #(
        .MAX (MAX_D_STREAK)
    ) u_streak (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_inc (w_d_win && i_if_req),
        .i_clr (w_if_win || !i_if_req),
        .o_sat (w_sat)
    );

    always_comb begin
        o_mem_read   = 1'b0;
        o_mem_write  = 1'b0;
        o_mem_addr   = '0;
        o_mem_funct3 = 3'b000;
        o_mem_wdata  = 32'd0;
        if (w_d_win) begin
            o_mem_read   = !i_d_we && w_d_access;
            o_mem_write  = i_d_we && w_d_access;
            o_mem_addr   = i_d_addr;
            o_mem_funct3 = i_d_funct3;
            o_mem_wdata  = i_d_wdata;
        end else if (w_if_win) begin
            o_mem_read   = 1'b1;
            o_mem_addr   = i_if_addr;
            o_mem_funct3 = F3_LW;
        end
    end

    assign o_if_gnt = w_if_win;
    assign o_d_gnt  = w_d_win;

    // State records who owned the port last cycle, which is exactly who gets a response now.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        if (w_d_win) begin
            w_next_state = SERVE_D;
        end else if (w_if_win) begin
            w_next_state = SERVE_I;
        end
    end

    always_comb begin
        o_if_rvalid = 1'b0;
        o_d_rvalid  = 1'b0;
        case (r_state)
            SERVE_I: o_if_rvalid = 1'b1;
            SERVE_D: o_d_rvalid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_rdata <= 32'd0;
            r_d_rdata  <= 32'd0;
        end else begin
            if (w_if_win) begin
                r_if_rdata <= i_mem_rdata;
            end
            if (w_d_win) begin
                r_d_rdata <= (!i_d_we && w_d_access) ? i_mem_rdata : 32'd0;
            end
        end
    end

    assign o_if_rdata = r_if_rdata;
    assign o_d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_data_mem_port_arbiter.sv
// tb/tb_data_mem_port_arbiter.sv - randomized self-checking bench with a byte-array reference model
module tb_data_mem_port_arbiter;
    import data_mem_arb_pkg::*;

    localparam int MAX_D = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]  d_funct3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata, mem_rdata;
`ifdef DATA_MEM_ARB_MISALIGN_EN
    logic        d_misalign;
`endif

    always #5 clk = ~clk;

    data_mem_port_arbiter #(.ADDR_W(8), .MAX_D_STREAK(MAX_D)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_funct3(d_funct3), .i_d_addr(d_addr),
        .i_d_wdata(d_wdata), .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_mem_read(mem_read), .o_mem_write(mem_write), .o_mem_addr(mem_addr),
        .o_mem_funct3(mem_funct3), .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
`ifdef DATA_MEM_ARB_MISALIGN_EN
        , .o_d_misalign(d_misalign)
`endif
    );

    // Environment memory: combinational read, written one cycle after the DUT asserts mem_write.
    logic [7:0] mem [256];
    logic [7:0] b0, b1, b2, b3;
    always_comb begin
        b0 = mem[mem_addr];
        b1 = mem[mem_addr + 8'd1];
        b2 = mem[mem_addr + 8'd2];
        b3 = mem[mem_addr + 8'd3];
        case (mem_funct3)
            3'b000:  mem_rdata = {{24{b0[7]}}, b0};
            3'b001:  mem_rdata = {{16{b1[7]}}, b1, b0};
            3'b010:  mem_rdata = {b3, b2, b1, b0};
            3'b100:  mem_rdata = {24'd0, b0};
            3'b101:  mem_rdata = {16'd0, b1, b0};
            default: mem_rdata = 32'd0;
        endcase
    end

    // Reference model state
    logic [7:0]  refm [256];
    int          streak;
    logic        exp_if_rv, exp_d_rv, exp_mis;
    logic [31:0] exp_if_rd, exp_d_rd;
    logic        obs_ig, obs_dg;
    int          total = 0;
    int          bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_ok(input logic [2:0] f, input logic we);
        return we ? (f < 3'd3) : (f != 3'd3 && f < 3'd6);
    endfunction

    function automatic bit ref_mis(input logic [2:0] f, input logic [7:0] a, input logic we);
`ifdef DATA_MEM_ARB_MISALIGN_EN
        int n = 1 << f[1:0];
        return ref_ok(f, we) && (n == 2 || n == 4) && (int'(a) % n != 0);
`else
        return (f == 3'd7) && (a == 8'd0) && we && 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [7:0] a, input logic [2:0] f);
        int n = 1 << f[1:0];
        logic [31:0] v = 32'd0;
        for (int k = 0; k < n; k++) v |= 32'(refm[8'(int'(a) + k)]) << (8 * k);
        if (!f[2] && n < 4 && v[8 * n - 1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // Called at posedge+1: drive, check at mid-cycle, advance model, return at next posedge+1.
    task automatic cycle(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                         input logic [2:0] df, input logic [7:0] da, input logic [31:0] dd);
        int          win;
        bit          acc, mis;
        logic        cw;
        logic [7:0]  ca;
        logic [2:0]  cf;
        logic [31:0] cd;
        if_req = ir; if_addr = ia;
        d_req = dr; d_we = dw; d_funct3 = df; d_addr = da; d_wdata = dd;
        #3;
        check("if_rvalid", 32'(if_rvalid), 32'(exp_if_rv));
        if (exp_if_rv) check("if_rdata", if_rdata, exp_if_rd);
        check("d_rvalid", 32'(d_rvalid), 32'(exp_d_rv));
        if (exp_d_rv) check("d_rdata", d_rdata, exp_d_rd);
`ifdef DATA_MEM_ARB_MISALIGN_EN
        check("d_misalign", 32'(d_misalign), 32'(exp_mis));
`endif
        win = (dr && !(ir && streak >= MAX_D)) ? 2 : (ir ? 1 : 0);
        mis = (win == 2) && ref_mis(df, da, dw);
        acc = (win == 2) && ref_ok(df, dw) && !mis;
        check("if_gnt", 32'(if_gnt), 32'(win == 1));
        check("d_gnt", 32'(d_gnt), 32'(win == 2));
        check("mem_read", 32'(mem_read), 32'(win == 1 || (acc && !dw)));
        check("mem_write", 32'(mem_write), 32'(acc && dw));
        check("mem_addr", 32'(mem_addr), 32'(win == 1 ? ia : (win == 2 ? da : 8'd0)));
        check("mem_funct3", 32'(mem_funct3), 32'(win == 1 ? 3'b010 : (win == 2 ? df : 3'd0)));
        if (win != 1) check("mem_wdata", mem_wdata, (win == 2) ? dd : 32'd0);
        obs_ig = if_gnt; obs_dg = d_gnt;
        cw = mem_write; ca = mem_addr; cf = mem_funct3; cd = mem_wdata;
        exp_if_rv = (win == 1);
        if (win == 1) exp_if_rd = ref_load(ia, 3'b010);
        exp_d_rv = (win == 2);
        exp_d_rd = (acc && !dw) ? ref_load(da, df) : 32'd0;
        exp_mis  = mis;
        if (acc && dw)
            for (int k = 0; k < (1 << df[1:0]); k++) refm[8'(int'(da) + k)] = dd[8 * k +: 8];
        if (win == 1 || !ir) streak = 0;
        else if (win == 2 && streak < MAX_D) streak++;
        @(posedge clk);
        #1;
        if (cw)
            for (int k = 0; k < (1 << cf[1:0]) && k < 4; k++) mem[8'(int'(ca) + k)] = cd[8 * k +: 8];
    endtask

    task automatic idle();
        cycle(1'b0, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat3, pat4;
        bit ip, dp, dw_r;
        logic [7:0] ia_r, da_r;
        logic [2:0] df_r;
        logic [31:0] dd_r;
        pat3 = 8'b0111_0111;
        pat4 = 8'b0000_0111;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
        end
        mem[0] = 8'd17; mem[1] = 8'd0; mem[2] = 8'd0; mem[3] = 8'd0;
        for (int i = 0; i < 256; i++) refm[i] = mem[i];
        streak = 0; exp_if_rv = 0; exp_d_rv = 0; exp_mis = 0; exp_if_rd = 0; exp_d_rd = 0;
        rst = 1'b1;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_funct3 = 0; d_addr = 0; d_wdata = 0;
        #1;
        check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        check("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // fetch of word 0
        cycle(1'b1, 8'd0, 1'b0, 1'b0, 3'd0, 8'd0, 32'd0);
        check("t1_if_rvalid", 32'(if_rvalid), 32'd1);
        check("t1_if_rdata", if_rdata, 32'd17);
        idle();

        // store then signed/unsigned byte loads
        cycle(1'b0, 8'd0, 1'b1, 1'b1, F3_SW, 8'd20, 32'hDEADBEEF);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, F3_LB, 8'd20, 32'd0);
        check("t2_lb", d_rdata, 32'hFFFFFFEF);
        cycle(1'b0, 8'd0, 1'b1, 1'b0, F3_LBU, 8'd23, 32'd0);
        check("t2_lbu", d_rdata, 32'h000000DE);
        idle();

        // contention: D,D,D,I,D,D,D,I
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 8'(4 * i), 1'b1, 1'b0, F3_LW, 8'(64 + 4 * i), 32'd0);
            check("t3_order", 32'(obs_dg), 32'(pat3[i]));
        end
        idle();

        // reset with a load in flight and a partial streak
        cycle(1'b1, 8'h10, 1'b1, 1'b0, F3_LW, 8'h40, 32'd0);
        cycle(1'b1, 8'h10, 1'b1, 1'b0, F3_LW, 8'h44, 32'd0);
        rst = 1'b1;
        #1;
        check("t4_rst_d_rvalid", 32'(d_rvalid), 32'd0);
        check("t4_rst_d_gnt", 32'(d_gnt), 32'd0);
        check("t4_rst_if_gnt", 32'(if_gnt), 32'd0);
        check("t4_rst_mem_read", 32'(mem_read), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        streak = 0; exp_if_rv = 0; exp_d_rv = 0; exp_mis = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 8'h10, 1'b1, 1'b0, F3_LW, 8'h48, 32'd0);
            check("t4_order", 32'(obs_dg), 32'(pat4[i]));
        end
        idle();

        // invalid funct3 load
        cycle(1'b0, 8'd0, 1'b1, 1'b0, 3'b111, 8'd40, 32'd0);
        check("t5_inv_rvalid", 32'(d_rvalid), 32'd1);
        check("t5_inv_rdata", d_rdata, 32'd0);
`ifdef DATA_MEM_ARB_MISALIGN_EN
        cycle(1'b0, 8'd0, 1'b1, 1'b1, F3_SW, 8'd2, 32'h12345678);
        check("t5_mis_st", 32'(d_misalign), 32'd1);
        for (int k = 2; k < 6; k++) check("t5_mem_keep", 32'(mem[k]), 32'(refm[k]));
        cycle(1'b0, 8'd0, 1'b1, 1'b0, F3_LW, 8'd2, 32'd0);
        check("t5_mis_ld", 32'(d_misalign), 32'd1);
        check("t5_mis_rdata", d_rdata, 32'd0);
`endif
        idle();

        // randomized requesters holding their fields until granted
        ip = 0; dp = 0; ia_r = 0; da_r = 0; dw_r = 0; df_r = 0; dd_r = 0;
        repeat (500) begin
            if (!ip && $urandom_range(0, 2) != 0) begin
                ip = 1; ia_r = 8'($urandom);
            end
            if (!dp && $urandom_range(0, 1) != 0) begin
                dp = 1; dw_r = 1'($urandom); df_r = 3'($urandom_range(0, 7));
                da_r = 8'($urandom); dd_r = $urandom;
            end
            cycle(ip, ia_r, dp, dw_r, df_r, da_r, dd_r);
            if (obs_ig) ip = 0;
            if (obs_dg) dp = 0;
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
